// File: rtl/tsp_pkg.sv
// Shared constants and types for the instruction fetch/dispatch path.
package tsp_pkg;

  localparam int unsigned INSTR_WIDTH_DEFAULT     = 32;
  localparam int unsigned IMEM_ADDR_WIDTH_DEFAULT = 10;

  // Opcode field of an instruction word
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] HALT_OPCODE = 6'h3F;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2,
    FS_DONE  = 2'd3
  } fetch_state_e;

  // Plain-vector encodings of the fetch states for legacy-style state registers
  localparam logic [1:0] ST_IDLE  = FS_IDLE;
  localparam logic [1:0] ST_FETCH = FS_FETCH;
  localparam logic [1:0] ST_DRAIN = FS_DRAIN;
  localparam logic [1:0] ST_DONE  = FS_DONE;

  function automatic logic is_halt(input logic [OPC_W-1:0] opc);
    return opc == HALT_OPCODE;
  endfunction

endpackage

// File: rtl/icu_instr_fifo.sv
// Synchronous first-word-fall-through dispatch buffer with occupancy count.
module icu_instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop, full;

  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && (count_q != '0);
  // A push at full is only legal when the head leaves in the same cycle
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/icu_fetch_controller.sv
// Fetches a program from instruction memory until a HALT word and dispatches it in order.
module icu_fetch_controller
  import tsp_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH          = INSTR_WIDTH_DEFAULT,
  parameter int unsigned INSTR_MEM_ADDR_WIDTH = IMEM_ADDR_WIDTH_DEFAULT,
  parameter int unsigned FIFO_DEPTH           = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [INSTR_MEM_ADDR_WIDTH-1:0] base_addr,
  output logic                            imem_rd_en,
  output logic [INSTR_MEM_ADDR_WIDTH-1:0] imem_addr,
  input  logic [INSTR_WIDTH-1:0]          imem_data,
  output logic [INSTR_WIDTH-1:0]          instr_out,
  output logic                            instruction_valid,
  input  logic                            instr_ready,
  output logic                            fifo_empty,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  logic [1:0]                      state_q, state_d;
  logic [INSTR_MEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                            rd_pend_q;
  logic [CW-1:0]                   fifo_count;
  logic [CW:0]                     inflight;
  logic                            halt_ret, credit_ok, push, pop;

  // Memory latency is exactly one cycle, so at most one read is ever in flight
  assign halt_ret  = rd_pend_q && is_halt(imem_data[OPC_MSB:OPC_LSB]);
  assign inflight  = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
  assign credit_ok = (inflight < (CW+1)'(FIFO_DEPTH));

  // The strobe is suppressed while a HALT is returning so nothing past it is fetched
  assign imem_rd_en = (state_q == ST_FETCH) && credit_ok && !halt_ret;
  assign imem_addr  = pc_q;

  assign push = rd_pend_q && (state_q == ST_FETCH) && !halt_ret;
  assign pop  = instruction_valid && instr_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = base_addr;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (halt_ret) begin
          state_d = ST_DRAIN;
        end else if (imem_rd_en) begin
          pc_d = pc_q + INSTR_MEM_ADDR_WIDTH'(1);
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !rd_pend_q) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      rd_pend_q <= imem_rd_en;
    end
  end

  icu_instr_fifo #(
    .WIDTH (INSTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (imem_data),
    .pop_i       (pop),
    .head_o      (instr_out),
    .valid_o     (instruction_valid),
    .count_o     (fifo_count)
  );

  assign fifo_empty = !instruction_valid;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_icu_fetch_controller.sv
// Self-checking bench: program-level reference model plus directed and random runs.
module tb_icu_fetch_controller;

  localparam int IW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;
  localparam logic [IW-1:0] HALT_W = 32'hFC000000;

  logic          clk = 1'b0;
  logic          rst, start, instr_ready;
  logic [AW-1:0] base_addr, imem_addr;
  logic          imem_rd_en, instruction_valid, fifo_empty, busy, done;
  logic [IW-1:0] imem_data, instr_out;

  icu_fetch_controller #(
    .INSTR_WIDTH          (IW),
    .INSTR_MEM_ADDR_WIDTH (AW),
    .FIFO_DEPTH           (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .base_addr         (base_addr),
    .imem_rd_en        (imem_rd_en),
    .imem_addr         (imem_addr),
    .imem_data         (imem_data),
    .instr_out         (instr_out),
    .instruction_valid (instruction_valid),
    .instr_ready       (instr_ready),
    .fifo_empty        (fifo_empty),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  // Instruction memory: data one cycle after the strobe, noise otherwise
  logic [IW-1:0] mem [0:1023];
  always @(posedge clk) imem_data <= imem_rd_en ? mem[imem_addr] : IW'($urandom);

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state
  int            ph = 0;         // 0 idle, 1 fetching, 2 draining, 3 done pulse
  logic [IW-1:0] mbuf[$];        // words the buffer must hold
  int            pend = 0;       // a read issued last cycle
  logic [AW-1:0] pend_addr = '0;
  logic [AW-1:0] mpc = '0;
  logic [IW-1:0] prog_q[$];      // program order still to be dispatched
  logic [IW-1:0] stage[$];

  // Per-run observations
  int            cyc = 0;
  int            start_cyc, first_valid_cyc, first_pop_cyc, last_pop_cyc;
  int            done_cnt, busy_cnt;
  logic [IW-1:0] popped[$];
  logic [AW-1:0] rd_log[$];

  always @(negedge clk) begin : mon
    logic          halt_ret, exp_rd, exp_valid, drain_ok;
    logic [IW-1:0] exp_head, pw;
    int            nph;
    cyc++;
    if (rst) begin
      ph = 0; mbuf.delete(); pend = 0; mpc = '0; pend_addr = '0;
    end else begin
      pw        = mem[pend_addr];
      halt_ret  = (pend != 0) && (pw[31:26] == 6'h3F);
      exp_rd    = (ph == 1) && (mbuf.size() + pend < DEPTH) && !halt_ret;
      exp_valid = (mbuf.size() != 0);
      exp_head  = exp_valid ? mbuf[0] : '0;
      check("rd_en", 64'(imem_rd_en), 64'(exp_rd));
      if (exp_rd) check("imem_addr", 64'(imem_addr), 64'(mpc));
      check("valid", 64'(instruction_valid), 64'(exp_valid));
      check("instr_out", 64'(instr_out), 64'(exp_head));
      check("fifo_empty", 64'(fifo_empty), 64'(!exp_valid));
      check("busy", 64'(busy), 64'(ph != 0));
      check("done", 64'(done), 64'(ph == 3));

      if (ph == 0 && start) start_cyc = cyc;
      if (instruction_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (imem_rd_en) rd_log.push_back(imem_addr);
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (instruction_valid && instr_ready) begin
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        popped.push_back(instr_out);
        if (prog_q.size() == 0) begin
          total++; bad++;
          $display("FAIL dispatch: got 0x%0h, required no further word", instr_out);
        end else begin
          check("order", 64'(instr_out), 64'(prog_q.pop_front()));
        end
      end

      drain_ok = (ph == 2) && !exp_valid && (pend == 0);
      if (exp_valid && instr_ready) void'(mbuf.pop_front());
      if (ph == 1 && pend != 0 && !halt_ret) mbuf.push_back(pw);
      nph = ph;
      case (ph)
        0: if (start) begin nph = 1; mpc = base_addr; end
        1: if (halt_ret) nph = 2;
        2: if (drain_ok) nph = 3;
        default: nph = 0;
      endcase
      if (exp_rd) begin pend_addr = mpc; mpc = mpc + AW'(1); end
      pend = exp_rd ? 1 : 0;
      ph   = nph;
    end
  end

  function automatic logic [IW-1:0] nonhalt();
    logic [IW-1:0] w;
    w = IW'($urandom);
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  task automatic load_prog(input logic [AW-1:0] b, input logic [IW-1:0] haltw);
    logic [AW-1:0] a;
    for (int i = 0; i < stage.size(); i++) begin
      a = b + AW'(i);
      mem[a] = stage[i];
    end
    a = b + AW'(stage.size());
    mem[a] = haltw;
    prog_q = stage;
  endtask

  task automatic clear_run();
    popped.delete(); rd_log.delete();
    start_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
    done_cnt = 0; busy_cnt = 0;
  endtask

  // Called just after a rising edge with the DUT idle
  task automatic do_start(input logic [AW-1:0] b);
    base_addr = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ~b;
  endtask

  task automatic wait_idle(input int budget, input int mode);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (!busy) return;
      if (mode == 0) instr_ready = 1'b1;
      else if (mode == 1) begin
        instr_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) begin
          start = 1'b1;
          base_addr = AW'($urandom);
        end
      end
    end
    total++; bad++;
    $display("FAIL timeout: busy=%0b after %0d cycles, required 0", busy, budget);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; instr_ready = 1'b0; base_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = nonhalt();
    #1;
    check("rst_rd_en", 64'(imem_rd_en), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_valid", 64'(instruction_valid), 64'd0);
    check("rst_instr", 64'(instr_out), 64'd0);
    check("rst_empty", 64'(fifo_empty), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Three-word program with HALT, consumer always ready
    stage = '{32'h00000001, 32'h00000002};
    load_prog(10'h010, HALT_W);
    clear_run(); instr_ready = 1'b1;
    do_start(10'h010);
    wait_idle(50, 0);
    check("t1_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("t1_count", 64'(popped.size()), 64'd2);
    if (popped.size() == 2) begin
      check("t1_w0", 64'(popped[0]), 64'h1);
      check("t1_w1", 64'(popped[1]), 64'h2);
    end
    check("t1_back_to_back", 64'(last_pop_cyc - first_pop_cyc), 64'd1);
    check("t1_done_pulses", 64'(done_cnt), 64'd1);

    // Consumer stalled: reads stop at the credit limit, head holds
    stage = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
    load_prog(10'h010, HALT_W);
    clear_run(); instr_ready = 1'b0;
    do_start(10'h010);
    repeat (9) @(posedge clk);
    #1;
    check("t2_reads_in_stall", 64'(rd_log.size()), 64'(DEPTH));
    check("t2_head_held", 64'(instr_out), 64'h1);
    instr_ready = 1'b1;
    wait_idle(60, 0);
    check("t2_count", 64'(popped.size()), 64'd6);
    check("t2_done_pulses", 64'(done_cnt), 64'd1);

    // Address wrap at the top of memory
    stage = '{32'h0000000A, 32'h0000000B, 32'h0000000C};
    load_prog(10'h3FE, HALT_W);
    clear_run(); instr_ready = 1'b1;
    do_start(10'h3FE);
    wait_idle(50, 0);
    check("t3_nreads", 64'(rd_log.size()), 64'd4);
    if (rd_log.size() == 4) begin
      check("t3_a0", 64'(rd_log[0]), 64'h3FE);
      check("t3_a1", 64'(rd_log[1]), 64'h3FF);
      check("t3_a2", 64'(rd_log[2]), 64'h000);
      check("t3_a3", 64'(rd_log[3]), 64'h001);
    end
    check("t3_count", 64'(popped.size()), 64'd3);

    // HALT as the very first word
    stage.delete();
    load_prog(10'h200, HALT_W);
    clear_run(); instr_ready = 1'b1;
    do_start(10'h200);
    wait_idle(50, 0);
    check("t4_no_valid", 64'(first_valid_cyc < 0), 64'd1);
    check("t4_done_pulses", 64'(done_cnt), 64'd1);
    check("t4_busy_le4", 64'(busy_cnt >= 1 && busy_cnt <= 4), 64'd1);

    // Reset mid-run with two words buffered, then restart at once
    stage = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'h16};
    load_prog(10'h040, HALT_W);
    clear_run(); instr_ready = 1'b0;
    do_start(10'h040);
    repeat (3) @(posedge clk);
    #1;
    check("t5_pre_valid", 64'(instruction_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rd_en", 64'(imem_rd_en), 64'd0);
    check("t5_addr", 64'(imem_addr), 64'd0);
    check("t5_valid", 64'(instruction_valid), 64'd0);
    check("t5_instr", 64'(instr_out), 64'd0);
    check("t5_empty", 64'(fifo_empty), 64'd1);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    stage = '{32'h21, 32'h22, 32'h23};
    load_prog(10'h080, HALT_W);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_run(); instr_ready = 1'b1;
    do_start(10'h080);
    wait_idle(50, 0);
    check("t5_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    check("t5_count", 64'(popped.size()), 64'd3);
    if (popped.size() == 3) check("t5_w0", 64'(popped[0]), 64'h21);

    // Start pulses while busy must not disturb the run
    stage.delete();
    for (int i = 0; i < 8; i++) stage.push_back(32'h100 + IW'(i));
    load_prog(10'h100, HALT_W);
    clear_run(); instr_ready = 1'b1;
    do_start(10'h100);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 10'h2AA;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'h155;
    wait_idle(60, 1);
    check("t6_count", 64'(popped.size()), 64'd8);
    check("t6_first_addr", 64'(rd_log.size() > 0 ? rd_log[0] : 10'h3FF), 64'h100);

    // Sustained one word per cycle
    stage.delete();
    for (int i = 0; i < 16; i++) stage.push_back(nonhalt());
    load_prog(10'h300, HALT_W);
    clear_run(); instr_ready = 1'b1;
    do_start(10'h300);
    wait_idle(80, 0);
    check("t7_count", 64'(popped.size()), 64'd16);
    check("t7_throughput", 64'(last_pop_cyc - first_pop_cyc), 64'd15);

    // Randomized programs, bases and consumer back-pressure
    for (int r = 0; r < 25; r++) begin
      logic [AW-1:0] b;
      int            n;
      b = AW'($urandom);
      n = $urandom_range(0, 12);
      stage.delete();
      for (int i = 0; i < n; i++) stage.push_back(nonhalt());
      load_prog(b, {6'h3F, 26'($urandom)});
      clear_run();
      instr_ready = ($urandom_range(0, 1) != 0);
      do_start(b);
      wait_idle(300, 1);
      check("rand_count", 64'(popped.size()), 64'(n));
      check("rand_done_pulses", 64'(done_cnt), 64'd1);
      if (n > 0) check("rand_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
